// File: rtl/cyusb_slave_fifo_writer.sv
// Drains tagged 16-bit ADC words from the capture FIFO into the FX2 slave FIFO
// using asynchronous-mode SLWR/PKTEND strobes. A 4'hF tag marks end of
// sawtooth and commits a short packet. A 4'hE tag marks the start of a frame.
// The endpoint address changes only at packet boundaries.
module cyusb_slave_fifo_writer #(
  parameter int PKT_WORDS = 256,
  parameter int WR_SETUP  = 1,
  parameter int WR_PULSE  = 2,
  parameter int WR_HOLD   = 1
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        FIFO_ADDR,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        usb_flagb_n,
  output logic [15:0] usb_fd,
  output logic [1:0]  usb_fifoadr,
  output logic        usb_slwr_n,
  output logic        usb_pktend_n,
  output logic        usb_slrd_n,
  output logic        usb_sloe_n,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam int WC_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(PKT_WORDS - 1);
  localparam logic [7:0] T_SETUP = 8'(WR_SETUP - 1);
  localparam logic [7:0] T_PULSE = 8'(WR_PULSE - 1);
  localparam logic [7:0] T_HOLD  = 8'(WR_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, WAIT_FULL, SETUP, STROBE, HOLD, PKT_WAIT, PKTEND
  } state_t;

  state_t          state;
  logic [WC_W-1:0] word_cnt;
  logic [WC_W-1:0] wc_nxt;
  logic [7:0]      tmr;
  logic            eof;

  // The FX2 read side is unused; keep it permanently deasserted.
  assign usb_slrd_n = 1'b1;
  assign usb_sloe_n = 1'b1;
  assign busy       = (state != IDLE);

  // Word position after the write in progress; wraps at the packet size.
  always_comb begin
    wc_nxt = (word_cnt == WC_LAST) ? '0 : word_cnt + 1'b1;
  end

  // Write sequencer: one word in flight, all strobes registered.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_cnt     <= '0;
      tmr          <= '0;
      eof          <= 1'b0;
      fifo_rd_en   <= 1'b0;
      usb_fd       <= '0;
      usb_fifoadr  <= 2'b00;
      usb_slwr_n   <= 1'b1;
      usb_pktend_n <= 1'b1;
      frame_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (word_cnt == '0) usb_fifoadr <= FIFO_ADDR ? 2'b10 : 2'b00;
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= LATCH;
          end
        end
        LATCH: begin
          // rd_en is registered, so read data is valid on the cycle after it drops.
          fifo_rd_en <= 1'b0;
          if (!fifo_rd_en) begin
            usb_fd <= fifo_dout;
            eof    <= (fifo_dout[15:12] == 4'hF);
            if (fifo_dout[15:12] == 4'hE) frame_cnt <= frame_cnt + 8'd1;
            state  <= WAIT_FULL;
          end
        end
        WAIT_FULL: begin
          if (usb_flagb_n) begin
            tmr   <= T_SETUP;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            usb_slwr_n <= 1'b0;
            tmr        <= T_PULSE;
            state      <= STROBE;
          end else tmr <= tmr - 8'd1;
        end
        STROBE: begin
          if (tmr == '0) begin
            usb_slwr_n <= 1'b1;
            tmr        <= T_HOLD;
            state      <= HOLD;
          end else tmr <= tmr - 8'd1;
        end
        HOLD: begin
          if (tmr == '0) begin
            word_cnt <= wc_nxt;
            // An eof landing on a packet boundary is auto-committed by the FX2.
            state    <= (eof && wc_nxt != '0) ? PKT_WAIT : IDLE;
          end else tmr <= tmr - 8'd1;
        end
        PKT_WAIT: begin
          if (usb_flagb_n) begin
            usb_pktend_n <= 1'b0;
            tmr          <= T_PULSE;
            state        <= PKTEND;
          end
        end
        PKTEND: begin
          if (tmr == '0) begin
            usb_pktend_n <= 1'b1;
            word_cnt     <= '0;
            state        <= IDLE;
          end else tmr <= tmr - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cyusb_slave_fifo_writer.sv
// Randomized bench for cyusb_slave_fifo_writer. A queue-like FIFO model feeds
// the DUT; a monitor rebuilds the expected packet stream (position, endpoint,
// short-packet commits, frame count) from the tag rules and checks each strobe.
module tb_cyusb_slave_fifo_writer;

  localparam int N   = 4096;
  localparam int PKT = 256;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        FIFO_ADDR = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        usb_flagb_n = 1'b1;
  logic [15:0] usb_fd;
  logic [1:0]  usb_fifoadr;
  logic        usb_slwr_n, usb_pktend_n, usb_slrd_n, usb_sloe_n;
  logic [7:0]  frame_cnt;
  logic        busy;

  cyusb_slave_fifo_writer dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .FIFO_ADDR(FIFO_ADDR),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .usb_flagb_n(usb_flagb_n), .usb_fd(usb_fd), .usb_fifoadr(usb_fifoadr),
    .usb_slwr_n(usb_slwr_n), .usb_pktend_n(usb_pktend_n),
    .usb_slrd_n(usb_slrd_n), .usb_sloe_n(usb_sloe_n),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  initial forever #10 clk_50M = ~clk_50M;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Capture FIFO model: array plus pointers; data appears the cycle after rd_en.
  logic [15:0] mem [0:N-1];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial forever begin
    @(posedge clk_50M);
    if (fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_dout <= mem[rd_ptr % N];
      rd_ptr = rd_ptr + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % N] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // FLAGB driver: forced full, random, or never full.
  logic force_full = 1'b0;
  logic rand_flag = 1'b0;
  initial forever begin
    @(negedge clk_50M);
    usb_flagb_n = force_full ? 1'b0 : rand_flag ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Reference model state, rebuilt from the tag rules at each observed strobe.
  int mon_ptr = 0;
  int pos = 0;
  int frames = 0;
  int pend = 0;
  int n_wr = 0;
  int n_pk = 0;
  logic [1:0] ep = 2'b00;

  initial begin
    logic ps, pp;
    int slen, plen;
    logic [15:0] w, fd_fall;
    ps = 1'b1; pp = 1'b1; slen = 0; plen = 0; fd_fall = '0;
    forever begin
      @(negedge clk_50M);
      if (!rst_n) begin
        ps = 1'b1; pp = 1'b1; slen = 0; plen = 0;
        pos = 0; frames = 0; pend = 0;
      end else begin
        if (ps && !usb_slwr_n) begin
          chk("slwr_vs_pktend", usb_pktend_n, 1);
          chk("wr_available", mon_ptr < wr_ptr, 1);
          w = mem[mon_ptr % N];
          mon_ptr = mon_ptr + 1;
          chk("wr_data", usb_fd, w);
          if (pos == 0) ep = FIFO_ADDR ? 2'b10 : 2'b00;
          chk("wr_fifoadr", usb_fifoadr, ep);
          if (w[15:12] == 4'hE) frames = frames + 1;
          pos = (pos + 1) % PKT;
          if (w[15:12] == 4'hF && pos != 0) begin
            pend = pend + 1;
            pos = 0;
          end
          fd_fall = usb_fd;
          slen = 1;
          n_wr = n_wr + 1;
        end else if (!usb_slwr_n) begin
          slen = slen + 1;
        end else if (!ps) begin
          chk("slwr_width", slen, 2);
          chk("fd_stable", usb_fd, fd_fall);
        end
        if (pp && !usb_pktend_n) begin
          chk("pktend_expected", pend > 0, 1);
          chk("pktend_vs_slwr", usb_slwr_n, 1);
          if (pend > 0) pend = pend - 1;
          plen = 1;
          n_pk = n_pk + 1;
        end else if (!usb_pktend_n) begin
          plen = plen + 1;
        end else if (!pp) begin
          chk("pktend_width", plen, 2);
        end
        ps = usb_slwr_n;
        pp = usb_pktend_n;
      end
    end
  end

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (!(mon_ptr == wr_ptr && !busy && fifo_empty) && c < budget) begin
      @(negedge clk_50M);
      c++;
    end
    chk({tag, "_done"}, c < budget, 1);
    chk({tag, "_no_pending_pktend"}, pend, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, frames[7:0]);
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int c;
    c = 0;
    while (n_wr < target && c < budget) begin
      @(negedge clk_50M);
      c++;
    end
    chk({tag, "_reached"}, c < budget, 1);
  endtask

  task automatic do_reset();
    @(negedge clk_50M);
    rst_n = 1'b0;
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clk_50M);
    chk("rst_outputs", {fifo_rd_en, usb_fifoadr, usb_slwr_n, usb_pktend_n, busy},
        {1'b0, 2'b00, 1'b1, 1'b1, 1'b0});
    chk("rst_fd", usb_fd, 16'h0);
    chk("rst_frame_cnt", frame_cnt, 8'h0);
    chk("rst_ties", {usb_slrd_n, usb_sloe_n}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk_50M);
  endtask

  initial begin
    int w0, p0, c;
    logic any_low;
    logic [15:0] rw;

    // Three words, start tag first, no commit.
    do_reset();
    FIFO_ADDR = 1'b0;
    w0 = n_wr; p0 = n_pk;
    push(16'hE123); push(16'h1456); push(16'h2789);
    wait_done("t1", 200);
    chk("t1_writes", n_wr - w0, 3);
    chk("t1_pktends", n_pk - p0, 0);
    chk("t1_frame_cnt_one", frame_cnt, 8'd1);
    chk("t1_fifoadr", usb_fifoadr, 2'b00);

    // Short packet to EP6, committed by PKTEND.
    do_reset();
    FIFO_ADDR = 1'b1;
    repeat (2) @(negedge clk_50M);
    w0 = n_wr; p0 = n_pk;
    for (int i = 0; i < 4; i++) push(16'h1000 | 16'(i));
    push(16'hF0AB);
    wait_done("t2", 300);
    chk("t2_writes", n_wr - w0, 5);
    chk("t2_pktends", n_pk - p0, 1);
    chk("t2_fifoadr", usb_fifoadr, 2'b10);

    // Full packet whose last word is eof: auto-commit, then next packet word 0.
    FIFO_ADDR = 1'b0;
    repeat (2) @(negedge clk_50M);
    w0 = n_wr; p0 = n_pk;
    for (int i = 0; i < 255; i++) push(16'h3000 | 16'(i));
    push(16'hF000);
    push(16'h1001);
    wait_done("t3", 257 * 20);
    chk("t3_writes", n_wr - w0, 257);
    chk("t3_pktends", n_pk - p0, 0);

    // FLAGB held low: no strobe during the stall, data parked on the bus.
    force_full = 1'b1;
    repeat (2) @(negedge clk_50M);
    w0 = n_wr;
    push(16'hF555);
    any_low = 1'b0;
    repeat (20) begin
      @(negedge clk_50M);
      if (!usb_slwr_n) any_low = 1'b1;
    end
    chk("t4_no_write_when_full", any_low, 1'b0);
    chk("t4_fd_parked", usb_fd, 16'hF555);
    force_full = 1'b0;
    c = 0;
    while (usb_slwr_n && c < 8) begin
      @(negedge clk_50M);
      c++;
    end
    chk("t4_write_after_release", c < 8, 1);
    wait_done("t4", 100);
    chk("t4_writes", n_wr - w0, 1);

    // Endpoint toggled mid-packet takes effect only at the next packet.
    FIFO_ADDR = 1'b0;
    repeat (2) @(negedge clk_50M);
    w0 = n_wr;
    for (int i = 0; i < 256; i++)
      push(((i % 64) == 0) ? (16'hE000 | 16'(i)) : (16'h4000 | 16'(i)));
    push(16'h1111);
    push(16'hF222);
    wait_wr("t5_w10", w0 + 10, 400);
    FIFO_ADDR = 1'b1;
    wait_wr("t5_w256", w0 + 256, 256 * 20);
    chk("t5_fifoadr_held", usb_fifoadr, 2'b00);
    wait_wr("t5_w257", w0 + 257, 100);
    chk("t5_fifoadr_switched", usb_fifoadr, 2'b10);
    wait_done("t5", 200);

    // Random tags and random FLAGB back-pressure.
    FIFO_ADDR = 1'($urandom_range(0, 1));
    rand_flag = 1'b1;
    repeat (2) @(negedge clk_50M);
    w0 = n_wr;
    for (int i = 0; i < 200; i++) begin
      rw = 16'($urandom);
      push(rw);
    end
    wait_done("t6", 200 * 60);
    chk("t6_writes", n_wr - w0, 200);
    rand_flag = 1'b0;

    // Reset during STROBE: immediate reset values, word counter restarts.
    FIFO_ADDR = 1'b0;
    repeat (2) @(negedge clk_50M);
    push(16'hE234); push(16'h5678);
    c = 0;
    while (usb_slwr_n && c < 50) begin
      @(negedge clk_50M);
      c++;
    end
    chk("t7_in_strobe", usb_slwr_n, 1'b0);
    #5 rst_n = 1'b0;
    #1;
    chk("t7_async_slwr", usb_slwr_n, 1'b1);
    chk("t7_async_fd", usb_fd, 16'h0);
    chk("t7_async_busy", busy, 1'b0);
    chk("t7_async_frame_cnt", frame_cnt, 8'h0);
    wr_ptr = rd_ptr;
    FIFO_ADDR = 1'b1;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    w0 = n_wr; p0 = n_pk;
    push(16'h1AAA); push(16'hFBBB);
    wait_done("t7", 200);
    chk("t7_writes", n_wr - w0, 2);
    chk("t7_pktends", n_pk - p0, 1);
    chk("t7_fifoadr_resampled", usb_fifoadr, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
